// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter:
//                FSM state encoding, grant identity and default latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default memory access latency in cycles (legal range 1..15).
    localparam int c_default_latency = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Which requester owns the current (or most recent) transaction.
    typedef enum logic [0:0] {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_counter
//  Description : 4-bit access-latency counter. Load sets the count to 1 on
//                entry to the wait phase, increment advances it, and done
//                flags the cycle in which the count equals LATENCY.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_counter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = c_default_latency
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_done
);

    localparam logic [3:0] c_lat = 4'(LATENCY);

    logic [3:0] r_cnt;

    // Count register: load wins over increment; reset returns it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= 4'd1;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_done = (r_cnt == c_lat);

endmodule : mem_arb_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates an instruction-fetch port and a data port onto a
//                single fixed-latency memory port. One transaction in flight
//                at a time: IDLE -> WAIT (LATENCY cycles) -> RESP (valid).
//                Build option MEM_ARB_RR_EN: ties alternate between the two
//                ports instead of always favouring the data port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = c_default_latency,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    // instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    // data port
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    // shared memory port
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          busy
);

    arb_state_e    r_state;
    arb_gnt_e      r_gnt;
    logic          r_busy;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_if_valid;
    logic          r_dm_valid;

    logic          w_any_req;
    logic          w_pick_dm;
    logic          w_cnt_load;
    logic          w_cnt_inc;
    logic          w_cnt_done;

    assign w_any_req = if_req | dm_req;

    // Winner selection. r_gnt doubles as the last-grant record because it
    // only changes when a new transaction is granted.
`ifdef MEM_ARB_RR_EN
    assign w_pick_dm = dm_req & (~if_req | (r_gnt == GNT_IF));
`else
    assign w_pick_dm = dm_req;
`endif

    assign w_cnt_load = (r_state == IDLE) & w_any_req;
    assign w_cnt_inc  = (r_state == WAIT) & ~w_cnt_done;

    mem_arb_counter #(
        .LATENCY (LATENCY)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_inc  (w_cnt_inc),
        .o_done (w_cnt_done)
    );

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_IF;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
        end else begin
            // valid strobes are single-cycle unless set below
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state  <= WAIT;
                        r_busy   <= 1'b1;
                        r_mem_en <= 1'b1;
                        if (w_pick_dm) begin
                            r_gnt       <= GNT_DM;
                            r_mem_wr    <= dm_wr;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                        end else begin
                            r_gnt       <= GNT_IF;
                            r_mem_wr    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    // memory port stays stable until the final latency cycle
                    if (w_cnt_done) begin
                        r_state  <= RESP;
                        r_mem_en <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (r_gnt == GNT_DM) begin
                            r_dm_valid <= 1'b1;
                            if (!r_mem_wr) begin
                                r_dm_rdata <= mem_rdata;
                            end
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_mem_en <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Stimulus rounds push the
//                expected completions (port, cycle, data) computed from a
//                transaction-level model; a monitor pops on every valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    parameter int LATENCY = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_wr = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LATENCY), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        bit            is_dm;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [DW-1:0] dev_mem [MW];
    logic [DW-1:0] ref_mem [MW];

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 16) return 16'hA5A5;
        return DW'(a * 947) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory device: combinational read, write on clock edge
    assign mem_rdata = dev_mem[mem_addr[9:0]];
    initial begin
        for (int i = 0; i < MW; i++) dev_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en && mem_wr) dev_mem[mem_addr[9:0]] = mem_wdata;
        end
    end

    // monitor: pops an expectation on every valid pulse
    initial begin : monitor
        int            en_cnt;
        int            wr_cnt;
        logic [AW-1:0] seen_addr;
        logic [DW-1:0] seen_wdata;
        exp_t          e;
        en_cnt = 0; wr_cnt = 0; seen_addr = '0; seen_wdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                if (mem_wr) wr_cnt++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (if_valid || dm_valid) begin
                if (if_valid && dm_valid) begin
                    chk("both_valid", 32'(if_valid & dm_valid), 32'd0);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: if_valid=%0b dm_valid=%0b, expected no pulse (cycle %0d)",
                             if_valid, dm_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_port", 32'(dm_valid), 32'(e.is_dm));
                    chk("valid_cycle", cyc, e.cyc);
                    chk(e.is_dm ? "dm_rdata" : "if_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
                    chk("mem_en_cycles", en_cnt, LATENCY);
                    chk("mem_wr_cycles", wr_cnt, e.wr ? LATENCY : 0);
                    chk("mem_addr", seen_addr, e.addr);
                    if (e.wr) chk("mem_wdata", seen_wdata, e.wdata);
                end
                en_cnt = 0; wr_cnt = 0;
            end else if (rst || !busy) begin
                en_cnt = 0; wr_cnt = 0;
            end
        end
    end

    // transaction-level reference model state
    bit            last_dm = 1'b0;
    int            v_prev = -1000;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_dm_rdata = '0;

    task automatic serve(input bit is_dm, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int vcyc);
        exp_t e;
        e.is_dm = is_dm; e.wr = is_dm && wr; e.addr = a; e.wdata = d; e.cyc = vcyc;
        if (is_dm && wr) begin
            ref_mem[a[9:0]] = d;
            e.rdata = m_dm_rdata;
        end else if (is_dm) begin
            m_dm_rdata = ref_mem[a[9:0]];
            e.rdata = m_dm_rdata;
        end else begin
            m_if_rdata = ref_mem[a[9:0]];
            e.rdata = m_if_rdata;
        end
        exp_q.push_back(e);
        last_dm = is_dm;
        v_prev  = vcyc;
    endtask

    // one round: raise the chosen requests together, hold each until done
    task automatic run_round(input bit do_if, input logic [AW-1:0] ia,
                             input bit do_dm, input bit dwr,
                             input logic [AW-1:0] da, input logic [DW-1:0] dd);
        int k;
        int v1;
        int budget;
        bit dm_first;
        bit p_if;
        bit p_dm;
        // first IDLE cycle in which the requests can be sampled
        k = (cyc > v_prev + 1) ? cyc : v_prev + 1;
`ifdef MEM_ARB_RR_EN
        dm_first = do_dm && (!do_if || !last_dm);
`else
        dm_first = do_dm;
`endif
        v1 = k + LATENCY + 1;
        if (dm_first) begin
            serve(1'b1, dwr, da, dd, v1);
            if (do_if) serve(1'b0, 1'b0, ia, '0, v1 + LATENCY + 2);
        end else begin
            serve(1'b0, 1'b0, ia, '0, v1);
            if (do_dm) serve(1'b1, dwr, da, dd, v1 + LATENCY + 2);
        end
        if_req = do_if; if_addr = ia;
        dm_req = do_dm; dm_wr = dwr; dm_addr = da; dm_wdata = dd;
        p_if = do_if; p_dm = do_dm;
        budget = 2 * LATENCY + 12;
        while ((p_if || p_dm) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (p_if && if_valid) begin p_if = 1'b0; if_req = 1'b0; end
            if (p_dm && dm_valid) begin p_dm = 1'b0; dm_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("round_complete", {30'd0, p_if, p_dm}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int            sel;
        int            gap;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_valids", {30'd0, if_valid, dm_valid}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single fetch of a known word
        run_round(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        // write then read back on the data port
        run_round(1'b0, '0, 1'b1, 1'b1, 16'h0040, 16'h1234);
        @(negedge clk);
        run_round(1'b0, '0, 1'b1, 1'b0, 16'h0040, '0);
        @(negedge clk);
        // simultaneous requests
        run_round(1'b1, 16'h0002, 1'b1, 1'b0, 16'h0100, '0);
        @(negedge clk);
        // both held across four transactions
        run_round(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0004, '0);
        run_round(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0003, 16'hBEEF);
        // back-to-back fetches with the request held
        for (int i = 0; i < 5; i++) run_round(1'b1, AW'(16'h0020 + i), 1'b0, 1'b0, '0, '0);

        // reset in the middle of a wait phase
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0030;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        rst = 1'b0; if_req = 1'b0;
        last_dm = 1'b0; v_prev = -1000; m_if_rdata = '0; m_dm_rdata = '0;
        repeat (LATENCY + 4) @(negedge clk);
        chk("midrst_if_rdata", if_rdata, 0);
        run_round(1'b1, 16'h0030, 1'b0, 1'b0, '0, '0);

        // randomized rounds over a small address window to force hazards
        for (int r = 0; r < 40; r++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            sel = $urandom_range(1, 3);
            run_round(sel[0], AW'($urandom_range(0, 15)),
                      sel[1], 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 15)), DW'($urandom));
        end

        repeat (LATENCY + 4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
